// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit.
// Two-process FSM: a state/wait-counter register plus one combinational block
// producing the next state and every control output from the current state
// and the inputs. Memory-facing states (FETCH, MEM_READ, MEM_WRITE) hold the
// request until MemReady and fall into a sticky ERROR state if the memory
// stalls for MEM_TIMEOUT consecutive cycles.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OP,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic [1:0] PCSrc,
  output logic [1:0] RegDst,
  output logic [1:0] MemToReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [3:0] State,
  output logic       InstrDone,
  output logic       Error
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_EXEC_I    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_ERROR     = 4'd15
  } state_e;

  // Opcodes and function codes the controller understands.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  // ALU operation encodings.
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_LUI   = 3'b100;

  // A zero timeout still needs a one-bit counter to keep the logic legal.
  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(MEM_TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO    = CW'(0);

  state_e          state_q;
  state_e          state_d;
  logic [CW-1:0]   wait_cnt_q;
  logic [CW-1:0]   wait_cnt_d;
  logic            mem_state_s;
  logic            stall_s;
  logic [CW-1:0]   cnt_inc_s;
  logic            timeout_s;

  // Opcode dispatch out of DECODE; anything unrecognised is a fault.
  function automatic state_e decode_next(input logic [5:0] op);
    state_e nxt;
    case (op)
      OP_RTYPE:                 nxt = S_EXEC_R;
      OP_ADDI, OP_ORI, OP_LUI:  nxt = S_EXEC_I;
      OP_LW, OP_SW:             nxt = S_MEM_ADDR;
      OP_BEQ, OP_BNE:           nxt = S_BRANCH;
      OP_J, OP_JAL:             nxt = S_JUMP;
      default:                  nxt = S_ERROR;
    endcase
    return nxt;
  endfunction

  // ALU operation for the immediate-arithmetic group.
  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    logic [2:0] alu;
    case (op)
      OP_ADDI: alu = ALU_ADD;
      OP_ORI:  alu = ALU_OR;
      OP_LUI:  alu = ALU_LUI;
      default: alu = ALU_ADD;
    endcase
    return alu;
  endfunction

  // Stall detection and the timeout condition for memory-facing states.
  always_comb begin
    mem_state_s = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                  (state_q == S_MEM_WRITE);
    stall_s     = mem_state_s && !MemReady;
    if (&wait_cnt_q) begin
      cnt_inc_s = wait_cnt_q;
    end else begin
      cnt_inc_s = wait_cnt_q + CNT_ONE;
    end
    // The stall that pushes the counter onto MEM_TIMEOUT is the last one
    // tolerated; a ready in that same cycle never counts as a stall.
    timeout_s = (MEM_TIMEOUT > 0) && stall_s && (cnt_inc_s == TIMEOUT_VAL);
  end

  // Next-state and control-output decode; every output defaults to 0.
  always_comb begin
    state_d   = state_q;
    MemReq    = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IorD      = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCSrc     = 2'b00;
    RegDst    = 2'b00;
    MemToReg  = 2'b00;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ALUOp     = ALU_ADD;
    Error     = 1'b0;
    InstrDone = 1'b0;

    case (state_q)
      S_FETCH: begin
        MemReq  = 1'b1;
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        if (MemReady) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_s) begin
          state_d = S_ERROR;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        state_d = decode_next(OP);
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (OP == OP_LW) begin
          state_d = S_MEM_READ;
        end else begin
          state_d = S_MEM_WRITE;
        end
      end
      S_MEM_READ: begin
        MemReq  = 1'b1;
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (MemReady) begin
          state_d = S_MEM_WB;
        end else if (timeout_s) begin
          state_d = S_ERROR;
        end else begin
          state_d = S_MEM_READ;
        end
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemToReg = 2'b01;
        state_d  = S_FETCH;
      end
      S_MEM_WRITE: begin
        MemReq   = 1'b1;
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (MemReady) begin
          state_d = S_FETCH;
        end else if (timeout_s) begin
          state_d = S_ERROR;
        end else begin
          state_d = S_MEM_WRITE;
        end
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_RTYPE;
        if (Funct == FN_JR) begin
          PCWrite = 1'b1;
          PCSrc   = 2'b11;
          state_d = S_FETCH;
        end else begin
          state_d = S_R_WB;
        end
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 2'b01;
        state_d  = S_FETCH;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = imm_alu_op(OP);
        state_d = S_I_WB;
      end
      S_I_WB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_SUB;
        PCSrc   = 2'b01;
        PCWrite = ((OP == OP_BEQ) && Zero) || ((OP == OP_BNE) && !Zero);
        state_d = S_FETCH;
      end
      S_JUMP: begin
        PCWrite = 1'b1;
        PCSrc   = 2'b10;
        if (OP == OP_JAL) begin
          RegWrite = 1'b1;
          RegDst   = 2'b10;
          MemToReg = 2'b10;
        end else begin
          RegWrite = 1'b0;
        end
        state_d = S_JUMP;
        state_d = S_FETCH;
      end
      S_ERROR: begin
        Error   = 1'b1;
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_ERROR;
      end
    endcase

    // Retirement is any step back into FETCH; ERROR never retires.
    if ((state_q != S_FETCH) && (state_q != S_ERROR) && (state_d == S_FETCH)) begin
      InstrDone = 1'b1;
    end else begin
      InstrDone = 1'b0;
    end
  end

  // Wait counter: cleared on any state change, counts stalls, saturates.
  always_comb begin
    if (state_d != state_q) begin
      wait_cnt_d = CNT_ZERO;
    end else if (stall_s) begin
      wait_cnt_d = cnt_inc_s;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // State and wait-counter registers with asynchronous reset to FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= CNT_ZERO;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign State = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control (MEM_TIMEOUT = 4).
// Inputs change and outputs are sampled just after the falling edge.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] OP;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemReady;
  logic       MemReq, MemRead, MemWrite, IorD, IRWrite, PCWrite;
  logic [1:0] PCSrc, RegDst, MemToReg, ALUSrcB;
  logic       RegWrite, ALUSrcA, InstrDone, Error;
  logic [2:0] ALUOp;
  logic [3:0] State;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_control #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .OP(OP), .Funct(Funct), .Zero(Zero),
    .MemReady(MemReady), .MemReq(MemReq), .MemRead(MemRead),
    .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCSrc(PCSrc), .RegDst(RegDst), .MemToReg(MemToReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .State(State),
    .InstrDone(InstrDone), .Error(Error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; OP = 6'h00; Funct = 6'h20; Zero = 1'b0; MemReady = 1'b1;
    #2;
    chk("rst_state", State, 32'd0);
    chk("rst_error", Error, 32'd0);
    chk("rst_done", InstrDone, 32'd0);

    // R-type add, memory always ready: 0,1,6,7,0
    cyc(); reset = 1'b0; #1;
    chk("add_fetch_state", State, 32'd0);
    chk("add_fetch_memreq", MemReq, 32'd1);
    chk("add_fetch_irwrite", IRWrite, 32'd1);
    chk("add_fetch_pcwrite", PCWrite, 32'd1);
    chk("add_fetch_alusrcb", ALUSrcB, 32'd1);
    chk("add_fetch_done", InstrDone, 32'd0);
    cyc();
    chk("add_decode_state", State, 32'd1);
    chk("add_decode_alusrcb", ALUSrcB, 32'd3);
    cyc();
    chk("add_exec_state", State, 32'd6);
    chk("add_exec_aluop", ALUOp, 32'd2);
    chk("add_exec_alusrca", ALUSrcA, 32'd1);
    cyc();
    chk("add_wb_state", State, 32'd7);
    chk("add_wb_regwrite", RegWrite, 32'd1);
    chk("add_wb_regdst", RegDst, 32'd1);
    chk("add_wb_done", InstrDone, 32'd1);
    cyc();
    chk("add_back_fetch", State, 32'd0);
    chk("add_done_cleared", InstrDone, 32'd0);

    // lw with three cycles in MEM_READ: 0,1,2,3,3,3,4,0
    OP = 6'h23;
    cyc(); chk("lw_decode", State, 32'd1);
    cyc(); chk("lw_addr", State, 32'd2);
    chk("lw_addr_alusrcb", ALUSrcB, 32'd2);
    MemReady = 1'b0; #1;
    chk("lw_addr_noreq", MemReq, 32'd0);
    cyc(); chk("lw_read1", State, 32'd3);
    chk("lw_read1_memreq", MemReq, 32'd1);
    chk("lw_read1_iord", IorD, 32'd1);
    chk("lw_read1_memread", MemRead, 32'd1);
    cyc(); chk("lw_read2", State, 32'd3);
    chk("lw_read2_memreq", MemReq, 32'd1);
    cyc(); chk("lw_read3", State, 32'd3);
    MemReady = 1'b1; #1;
    chk("lw_read3_memreq", MemReq, 32'd1);
    chk("lw_read3_done", InstrDone, 32'd0);
    cyc(); chk("lw_wb", State, 32'd4);
    chk("lw_wb_memtoreg", MemToReg, 32'd1);
    chk("lw_wb_regwrite", RegWrite, 32'd1);
    chk("lw_wb_regdst", RegDst, 32'd0);
    chk("lw_wb_done", InstrDone, 32'd1);
    cyc(); chk("lw_back_fetch", State, 32'd0);

    // beq taken
    OP = 6'h04; Zero = 1'b1;
    cyc(); chk("beq_decode", State, 32'd1);
    cyc(); chk("beq_branch", State, 32'd10);
    chk("beq_pcwrite", PCWrite, 32'd1);
    chk("beq_pcsrc", PCSrc, 32'd1);
    chk("beq_aluop", ALUOp, 32'd1);
    cyc(); chk("beq_back_fetch", State, 32'd0);

    // bne with Zero=1 (not taken), then Zero=0 (taken)
    OP = 6'h05;
    cyc(); chk("bne_decode", State, 32'd1);
    cyc(); chk("bne_branch", State, 32'd10);
    chk("bne_z1_pcwrite", PCWrite, 32'd0);
    Zero = 1'b0; #1;
    chk("bne_z0_pcwrite", PCWrite, 32'd1);
    cyc(); chk("bne_back_fetch", State, 32'd0);

    // jal
    OP = 6'h03;
    cyc(); chk("jal_decode", State, 32'd1);
    cyc(); chk("jal_jump", State, 32'd11);
    chk("jal_pcwrite", PCWrite, 32'd1);
    chk("jal_pcsrc", PCSrc, 32'd2);
    chk("jal_regwrite", RegWrite, 32'd1);
    chk("jal_regdst", RegDst, 32'd2);
    chk("jal_memtoreg", MemToReg, 32'd2);
    cyc(); chk("jal_back_fetch", State, 32'd0);

    // jr
    OP = 6'h00; Funct = 6'h08;
    cyc(); chk("jr_decode", State, 32'd1);
    cyc(); chk("jr_exec", State, 32'd6);
    chk("jr_pcwrite", PCWrite, 32'd1);
    chk("jr_pcsrc", PCSrc, 32'd3);
    chk("jr_done", InstrDone, 32'd1);
    cyc(); chk("jr_back_fetch", State, 32'd0);

    // ori
    OP = 6'h0D;
    cyc(); chk("ori_decode", State, 32'd1);
    cyc(); chk("ori_exec", State, 32'd8);
    chk("ori_aluop", ALUOp, 32'd3);
    chk("ori_alusrcb", ALUSrcB, 32'd2);
    cyc(); chk("ori_wb", State, 32'd9);
    chk("ori_wb_regwrite", RegWrite, 32'd1);
    chk("ori_wb_done", InstrDone, 32'd1);
    cyc(); chk("ori_back_fetch", State, 32'd0);

    // sw, then asynchronous reset while waiting in MEM_WRITE
    OP = 6'h2B;
    cyc(); chk("sw_decode", State, 32'd1);
    MemReady = 1'b0;
    cyc(); chk("sw_addr", State, 32'd2);
    cyc(); chk("sw_write", State, 32'd5);
    chk("sw_memwrite", MemWrite, 32'd1);
    chk("sw_memread", MemRead, 32'd0);
    chk("sw_memreq", MemReq, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_state", State, 32'd0);
    chk("async_rst_done", InstrDone, 32'd0);
    chk("async_rst_error", Error, 32'd0);

    // Timeout: four stalled FETCH cycles then ERROR
    cyc(); reset = 1'b0; OP = 6'h3F;
    cyc(); chk("to_wait1", State, 32'd0);
    cyc(); chk("to_wait2", State, 32'd0);
    cyc(); chk("to_wait3", State, 32'd0);
    cyc(); chk("to_error_state", State, 32'd15);
    chk("to_error_flag", Error, 32'd1);
    chk("to_error_memreq", MemReq, 32'd0);
    chk("to_error_done", InstrDone, 32'd0);
    MemReady = 1'b1;
    cyc(); chk("to_error_sticky1", State, 32'd15);
    cyc(); chk("to_error_sticky2", State, 32'd15);
    reset = 1'b1; #1;
    chk("err_rst_state", State, 32'd0);
    chk("err_rst_flag", Error, 32'd0);

    // Ready on the would-be timeout cycle wins; then illegal opcode
    cyc(); reset = 1'b0; MemReady = 1'b0;
    cyc(); chk("prio_wait1", State, 32'd0);
    cyc(); chk("prio_wait2", State, 32'd0);
    cyc(); chk("prio_wait3", State, 32'd0);
    MemReady = 1'b1; #1;
    chk("prio_irwrite", IRWrite, 32'd1);
    cyc(); chk("prio_decode", State, 32'd1);
    cyc(); chk("illegal_state", State, 32'd15);
    chk("illegal_error", Error, 32'd1);
    chk("illegal_done", InstrDone, 32'd0);
    cyc(); chk("illegal_sticky", State, 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
